// File: rtl/mult_8x8_seq_ctrl.sv
// mult_8x8_seq_ctrl: sequential 8x8 unsigned multiplier. It uses one shared 4x4 multiplier
// to form the four nibble sub-products over four cycles and sums them in a 16-bit accumulator.
//
// Parameters:
//   ZERO_SKIP  1: a zero operand at accept completes at once with R=0. 0: every operation
//              runs the full sequence.
// Build option:
//   MULT_SEQ_SKIP_LL_EN  when defined, the A[3:0]*B[3:0] term is skipped. MUL then starts at
//                        step 1, so the result is approximate and arrives one cycle sooner.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair A/B is valid
//   in_ready   block can accept an operand pair (state IDLE)
//   A, B       8-bit unsigned operands
//   out_valid  R holds a completed product (state DONE)
//   out_ready  consumer takes R this cycle
//   R          16-bit unsigned product
//   busy       high in any state other than IDLE
module mult_8x8_seq_ctrl #(
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R,
  output logic        busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

`ifdef MULT_SEQ_SKIP_LL_EN
  localparam logic [1:0] FirstStep = 2'd1;
`else
  localparam logic [1:0] FirstStep = 2'd0;
`endif

  logic [1:0]  state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;

  logic [3:0]  nib_a, nib_b;
  logic [7:0]  sub_prod;
  logic [15:0] sub_shifted;
  logic        accept;
  logic        zero_op;

  // step[1] selects the A nibble and step[0] selects the B nibble. This gives the order
  // lo*lo, lo*hi, hi*lo, hi*hi.
  always_comb begin
    nib_a    = step_q[1] ? a_q[7:4] : a_q[3:0];
    nib_b    = step_q[0] ? b_q[7:4] : b_q[3:0];
    sub_prod = nib_a * nib_b;
    case (step_q)
      2'd0:    sub_shifted = {8'd0, sub_prod};
      2'd3:    sub_shifted = {sub_prod, 8'd0};
      default: sub_shifted = {4'd0, sub_prod, 4'd0};
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign R         = acc_q;
  assign accept    = in_valid && in_ready;
  assign zero_op   = (ZERO_SKIP != 0) && ((A == 8'd0) || (B == 8'd0));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = A;
          b_d     = B;
          acc_d   = 16'd0;
          step_d  = FirstStep;
          state_d = zero_op ? StDone : StMul;
        end
      end
      StMul: begin
        acc_d  = acc_q + sub_shifted;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Hold the result until it is taken. Going back to IDLE here also stops an accept
        // from landing on the handshake edge.
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= 2'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      acc_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
module tb_mult_8x8_seq_ctrl;

`ifdef MULT_SEQ_SKIP_LL_EN
  localparam int LatFull = 3;
  localparam bit SkipLl  = 1'b1;
`else
  localparam int LatFull = 4;
  localparam bit SkipLl  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] r;

  logic        nz_in_valid, nz_in_ready, nz_out_valid, nz_out_ready, nz_busy;
  logic [7:0]  nz_a, nz_b;
  logic [15:0] nz_r;

  mult_8x8_seq_ctrl #(.ZERO_SKIP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .out_valid(out_valid), .out_ready(out_ready), .R(r), .busy(busy)
  );

  mult_8x8_seq_ctrl #(.ZERO_SKIP(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .in_valid(nz_in_valid), .in_ready(nz_in_ready), .A(nz_a),
    .B(nz_b), .out_valid(nz_out_valid), .out_ready(nz_out_ready), .R(nz_r), .busy(nz_busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int r;
    int lat;
    int acc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         r_exact;
    int         r_skip;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  bit seen     = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented result against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: R=%0d with nothing expected (t=%0t)", r, $time);
      end else begin
        if (!seen) begin
          chk("latency", cycle - sb[0].acc, sb[0].lat);
          seen = 1'b1;
        end
        chk("R", int'(r), sb[0].r);
        chk("in_ready_while_done", int'(in_ready), 0);
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] va, input logic [7:0] vb, input int r_exact,
                      input int r_skip);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    a = va;
    b = vb;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    e.r   = SkipLl ? r_skip : r_exact;
    e.lat = ((va == 8'd0) || (vb == 8'd0)) ? 0 : LatFull;
    e.acc = cycle;
    sb.push_back(e);
    in_valid = 1'b0;
    // Scramble the inputs; the block must keep using the accepted pair.
    a = 8'hA5;
    b = 8'h5A;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  vec_t vecs[7] = '{
    '{8'd200, 8'd150, 30000, 29952},
    '{8'd255, 8'd255, 65025, 64800},
    '{8'd0,   8'd77,  0,     0},
    '{8'd18,  8'd52,  936,   928},
    '{8'd240, 8'd15,  3600,  3600},
    '{8'd1,   8'd255, 255,   240},
    '{8'd77,  8'd0,   0,     0}
  };

  initial begin
    int i;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    a            = 8'd0;
    b            = 8'd0;
    out_ready    = 1'b1;
    nz_in_valid  = 1'b0;
    nz_a         = 8'd0;
    nz_b         = 8'd0;
    nz_out_ready = 1'b1;
    #12;
    chk("rst_R", int'(r), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      send(vecs[k].a, vecs[k].b, vecs[k].r_exact, vecs[k].r_skip);
      wait_done();
    end

    // Backpressure: result held for several cycles before it is taken.
    #2;
    out_ready = 1'b0;
    send(8'd13, 8'd11, 143, 0);
    repeat (LatFull + 5) @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_in_ready", int'(in_ready), 1);
    chk("bp_idle_out_valid", int'(out_valid), 0);
    wait_done();

    // Zero operand with ZERO_SKIP=0 takes the full sequence.
    @(negedge clk);
    nz_in_valid = 1'b1;
    nz_a = 8'd0;
    nz_b = 8'd77;
    @(posedge clk);
    #1;
    nz_in_valid = 1'b0;
    nz_a = 8'hFF;
    nz_b = 8'hFF;
    i = 0;
    while (!nz_out_valid && i < 12) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("nz_latency", i, LatFull);
    chk("nz_R", int'(nz_r), 0);

    // Reset in the middle of an operation, while step 2 is being processed.
    send(8'd200, 8'd150, 30000, 29952);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_R", int'(r), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("no_valid_after_reset", int'(out_valid), 0);
    end
    send(8'd3, 8'd5, 15, 0);
    wait_done();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
